issue_bundle_sequencer: RTL and testbench
=========================================

# issue_bundle_sequencer

Sits between the instruction buffer and the multi-issue decoder. It accepts one VLIW bundle of up to ISSUE_WIDTH instructions and finds intra-bundle register hazards. It then issues the bundle over one or more cycles as hazard-free, program-ordered lane groups, so the decoder never receives a bundle with an intra-bundle RAW/WAW dependency. Throughput is one bundle per cycle when no split is needed.

## Interface
Parameters:
- ISSUE_WIDTH, 4: lanes per bundle, 2..8.
- STAT_W, 16: width of the split-statistics counter.

Ports (one clock, `clk_i`; reset `rst_i` is asynchronous and active-high):
- clk_i  in  1  clock.
- rst_i  in  1  async reset, active-high.
- flush_i  in  1  synchronous discard of the held bundle.
- in_valid_i  in  1  bundle valid.
- in_ready_o  out  1  bundle accepted when in_valid_i && in_ready_o.
- in_mask_i  in  ISSUE_WIDTH  valid lanes.
- in_instr_i  in  ISSUE_WIDTH×32  lane instructions; rd=[11:7], rs1=[19:15], rs2=[24:20].
- in_wb_i  in  ISSUE_WIDTH  lane writes rd (predecoded).
- in_rs1_rd_i / in_rs2_rd_i  in  ISSUE_WIDTH each  lane reads rs1 / rs2.
- out_valid_o  out  1  group valid to decoder.
- out_ready_i  in  1  decoder accepts group.
- out_mask_o  out  ISSUE_WIDTH  lanes in the current group.
- out_instr_o  out  ISSUE_WIDTH×32  held bundle, all lanes; lanes outside out_mask_o are don't-care.
- busy_o  out  1  bundle held (state HOLD).
- split_cnt_o  out  STAT_W  bundles issued in ≥2 groups, saturating.

## Operation
- States: IDLE and HOLD. Registered storage: bundle instr/wb/rs-read bits, and pending mask P.
- IDLE:
  - in_ready_o=1.
  - On accept with in_mask_i≠0: store the bundle, set P=in_mask_i, go to HOLD.
  - On accept with in_mask_i=0: drop the bundle, stay IDLE.
- Conflict(i,k), for i<k, both in P: wb[i] && rd[i]≠0 && (rs1_rd[k]&&rs1[k]==rd[i] || rs2_rd[k]&&rs2[k]==rd[i] || wb[k]&&rd[k]==rd[i]).
- Group selection:
  - f = lowest set bit of P.
  - Group = all P lanes from f up to, not including, the first P lane k>f that conflicts with any group lane before it.
  - Lanes with P=0 (masked holes) are skipped; they never conflict.
- HOLD:
  - out_valid_o=1, out_mask_o=group.
  - On handshake: P←P&~group.
  - If the new P=0 → IDLE, unless a new bundle is accepted in the same cycle, in which case stay in HOLD with the new bundle.
- in_ready_o in HOLD = out_ready_i && (group==P) && !flush_i. This is a combinational path from out_ready_i; the decoder must not derive out_ready_i from in_ready_o.
- flush_i:
  - The next state is IDLE with P=0.
  - No input is accepted that cycle (in_ready_o=0).
  - Any output handshake in the same cycle still counts toward split_cnt_o.

## Timing
- Reset values: IDLE, P=0, out_valid_o=0, out_mask_o=0, out_instr_o=0, busy_o=0, split_cnt_o=0, in_ready_o=1.
- Latency: a bundle accepted in cycle N presents its first group in cycle N+1. A bundle needing g groups occupies g cycles without backpressure.
- Back-to-back: the last-group handshake and a new accept can occur in the same cycle, giving no bubble.
- While out_valid_o && !out_ready_i: out_mask_o and out_instr_o hold stable and in_ready_o=0.
- Reset mid-HOLD: the held bundle is discarded and outputs go to their reset values immediately.

## Configuration
- `GARUDA_SEQ_STATS_EN`:
  - Defined: split_cnt_o increments by 1 on the first-group handshake of a bundle whose P is not cleared by that handshake. It saturates at 2^STAT_W−1.
  - Undefined: no counter register; split_cnt_o is tied to 0.

## Structure
- Package garuda_seq_pkg holds:
  - state enum seq_state_e {IDLE, HOLD};
  - field LSB constants RD_LSB=7, RS1_LSB=15, RS2_LSB=20 and REG_ADDR_W=5;
  - lane-mask typedef, parameterised by width at use.
- Sub-module issue_group_picker: purely combinational. Inputs are P, instr, wb, rs1_rd, rs2_rd; output is the group mask. It is instantiated once.

## Test plan
- Independent bundle: mask 1111, rd x1..x4, sources x10..x13 → single group 1111 in cycle N+1, split_cnt_o stays 0.
- RAW split: lane0 add x5 (wb), lane2 reads rs1=x5, mask 1111 → groups 0011 then 1100 in consecutive cycles, split_cnt_o=1.
- x0 exemption and holes:
  - lane0 writes x0, lane1 reads x0 → single group 1111.
  - mask 1010, lane3 reads rd of lane1 → groups 0010 then 1000.
- Backpressure: out_ready_i=0 for 3 cycles during group 0011 → out_mask_o/out_instr_o constant, in_ready_o=0, busy_o=1.
- Back-to-back: in_valid_i held high with alternating independent and split bundles → no idle cycle between the last group and the next bundle's first group.
- Flush/reset: flush_i in HOLD with P=1100 → next cycle out_valid_o=0, busy_o=0, and the input offered that cycle is not accepted. Asserting rst_i mid-HOLD → all outputs at reset values immediately.

Source files
------------

// File: rtl/garuda_seq_pkg.sv
// Shared types and instruction-field constants for the issue bundle sequencer.
package garuda_seq_pkg;

  typedef enum logic [0:0] {IDLE, HOLD} seq_state_e;

  localparam int unsigned RD_LSB     = 7;
  localparam int unsigned RS1_LSB    = 15;
  localparam int unsigned RS2_LSB    = 20;
  localparam int unsigned REG_ADDR_W = 5;

  // Widest supported bundle; narrower users take the low ISSUE_WIDTH bits.
  localparam int unsigned MAX_ISSUE_WIDTH = 8;
  typedef logic [MAX_ISSUE_WIDTH-1:0] lane_mask_t;

  // True when later lane k must not issue alongside earlier lane i.
  function automatic logic lane_conflict(input logic [31:0] instr_i, input logic wb_i,
                                         input logic [31:0] instr_k, input logic wb_k,
                                         input logic rs1_rd_k, input logic rs2_rd_k);
    logic [REG_ADDR_W-1:0] rd_i;
    logic                  hit;
    rd_i = instr_i[RD_LSB +: REG_ADDR_W];
    hit  = (rs1_rd_k && (instr_k[RS1_LSB +: REG_ADDR_W] == rd_i)) ||
           (rs2_rd_k && (instr_k[RS2_LSB +: REG_ADDR_W] == rd_i)) ||
           (wb_k     && (instr_k[RD_LSB  +: REG_ADDR_W] == rd_i));
    return wb_i && (rd_i != '0) && hit;
  endfunction

endpackage

// File: rtl/issue_group_picker.sv
// Combinational selection of the next hazard-free, program-ordered lane group.
module issue_group_picker
  import garuda_seq_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH = 4
) (
  input  logic [ISSUE_WIDTH-1:0]    pend_i,
  input  logic [ISSUE_WIDTH*32-1:0] instr_i,
  input  logic [ISSUE_WIDTH-1:0]    wb_i,
  input  logic [ISSUE_WIDTH-1:0]    rs1_rd_i,
  input  logic [ISSUE_WIDTH-1:0]    rs2_rd_i,
  output logic [ISSUE_WIDTH-1:0]    group_o
);

  logic [ISSUE_WIDTH-1:0] grp;
  logic                   stopped;
  logic                   hit;

  // The lowest pending lane never sees a conflict, so it always starts the group.
  always_comb begin
    grp     = '0;
    stopped = 1'b0;
    hit     = 1'b0;
    for (int k = 0; k < int'(ISSUE_WIDTH); k++) begin
      if (pend_i[k] && !stopped) begin
        hit = 1'b0;
        for (int i = 0; i < int'(ISSUE_WIDTH); i++) begin
          if ((i < k) && grp[i] &&
              lane_conflict(instr_i[i*32 +: 32], wb_i[i], instr_i[k*32 +: 32], wb_i[k],
                            rs1_rd_i[k], rs2_rd_i[k])) begin
            hit = 1'b1;
          end
        end
        if (hit) begin
          stopped = 1'b1;
        end else begin
          grp[k] = 1'b1;
        end
      end
    end
  end

  assign group_o = grp;

endmodule

// File: rtl/issue_bundle_sequencer.sv
// Holds one VLIW bundle and issues it as hazard-free lane groups.
// Optional split statistics counter enabled by GARUDA_SEQ_STATS_EN.
module issue_bundle_sequencer
  import garuda_seq_pkg::*;
#(
  parameter int unsigned ISSUE_WIDTH = 4,
  parameter int unsigned STAT_W      = 16
) (
  input  logic                      clk_i,
  input  logic                      rst_i,
  input  logic                      flush_i,
  input  logic                      in_valid_i,
  output logic                      in_ready_o,
  input  logic [ISSUE_WIDTH-1:0]    in_mask_i,
  input  logic [ISSUE_WIDTH*32-1:0] in_instr_i,
  input  logic [ISSUE_WIDTH-1:0]    in_wb_i,
  input  logic [ISSUE_WIDTH-1:0]    in_rs1_rd_i,
  input  logic [ISSUE_WIDTH-1:0]    in_rs2_rd_i,
  output logic                      out_valid_o,
  input  logic                      out_ready_i,
  output logic [ISSUE_WIDTH-1:0]    out_mask_o,
  output logic [ISSUE_WIDTH*32-1:0] out_instr_o,
  output logic                      busy_o,
  output logic [STAT_W-1:0]         split_cnt_o
);

  seq_state_e                state_q, state_d;
  logic [ISSUE_WIDTH-1:0]    p_q, p_d;
  logic [ISSUE_WIDTH*32-1:0] instr_q, instr_d;
  logic [ISSUE_WIDTH-1:0]    wb_q, wb_d;
  logic [ISSUE_WIDTH-1:0]    rs1_rd_q, rs1_rd_d;
  logic [ISSUE_WIDTH-1:0]    rs2_rd_q, rs2_rd_d;
  logic [ISSUE_WIDTH-1:0]    group;
  logic                      out_hs;
  logic                      in_acc;

  issue_group_picker #(
    .ISSUE_WIDTH(ISSUE_WIDTH)
  ) u_picker (
    .pend_i  (p_q),
    .instr_i (instr_q),
    .wb_i    (wb_q),
    .rs1_rd_i(rs1_rd_q),
    .rs2_rd_i(rs2_rd_q),
    .group_o (group)
  );

  always_comb begin
    state_d     = state_q;
    p_d         = p_q;
    instr_d     = instr_q;
    wb_d        = wb_q;
    rs1_rd_d    = rs1_rd_q;
    rs2_rd_d    = rs2_rd_q;
    out_valid_o = (state_q == HOLD);
    busy_o      = (state_q == HOLD);
    out_mask_o  = (state_q == HOLD) ? group : '0;
    // Accepting in HOLD requires the current group to drain the whole bundle.
    in_ready_o  = (state_q == IDLE) ? !flush_i : (out_ready_i && (group == p_q) && !flush_i);
    out_hs      = out_valid_o && out_ready_i;
    in_acc      = in_valid_i && in_ready_o;

    if (out_hs) begin
      p_d = p_q & ~group;
      if (p_d == '0) begin
        state_d = IDLE;
      end
    end
    if (in_acc && (in_mask_i != '0)) begin
      state_d  = HOLD;
      p_d      = in_mask_i;
      instr_d  = in_instr_i;
      wb_d     = in_wb_i;
      rs1_rd_d = in_rs1_rd_i;
      rs2_rd_d = in_rs2_rd_i;
    end
    if (flush_i) begin
      state_d = IDLE;
      p_d     = '0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      p_q      <= '0;
      instr_q  <= '0;
      wb_q     <= '0;
      rs1_rd_q <= '0;
      rs2_rd_q <= '0;
    end else begin
      state_q  <= state_d;
      p_q      <= p_d;
      instr_q  <= instr_d;
      wb_q     <= wb_d;
      rs1_rd_q <= rs1_rd_d;
      rs2_rd_q <= rs2_rd_d;
    end
  end

  assign out_instr_o = instr_q;

`ifdef GARUDA_SEQ_STATS_EN
  logic              first_q, first_d;
  logic [STAT_W-1:0] split_q, split_d;

  // first_q marks that the next handshake is the bundle's first group.
  always_comb begin
    first_d = first_q;
    split_d = split_q;
    if (out_hs) begin
      first_d = 1'b0;
      if (first_q && ((p_q & ~group) != '0) && (split_q != '1)) begin
        split_d = split_q + STAT_W'(1);
      end
    end
    if (in_acc && (in_mask_i != '0)) begin
      first_d = 1'b1;
    end
    if (flush_i) begin
      first_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      first_q <= 1'b0;
      split_q <= '0;
    end else begin
      first_q <= first_d;
      split_q <= split_d;
    end
  end

  assign split_cnt_o = split_q;
`else
  assign split_cnt_o = '0;
`endif

endmodule

// File: tb/tb_issue_bundle_sequencer.sv
// Self-checking bench: directed test-plan cases plus randomized traffic against a group-list model.
module tb_issue_bundle_sequencer;

  localparam int W  = 4;
  localparam int SW = 3;
`ifdef GARUDA_SEQ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            flush = 1'b0;
  logic            in_valid = 1'b0;
  logic            out_ready = 1'b0;
  logic [W-1:0]    in_mask = '0;
  logic [W-1:0]    in_wb = '0;
  logic [W-1:0]    in_r1 = '0;
  logic [W-1:0]    in_r2 = '0;
  logic [W*32-1:0] in_instr = '0;
  logic            in_ready_o;
  logic            out_valid_o;
  logic [W-1:0]    out_mask_o;
  logic [W*32-1:0] out_instr_o;
  logic            busy_o;
  logic [SW-1:0]   split_cnt_o;

  always #5 clk = ~clk;

  issue_bundle_sequencer #(
    .ISSUE_WIDTH(W),
    .STAT_W     (SW)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .flush_i    (flush),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready_o),
    .in_mask_i  (in_mask),
    .in_instr_i (in_instr),
    .in_wb_i    (in_wb),
    .in_rs1_rd_i(in_r1),
    .in_rs2_rd_i(in_r2),
    .out_valid_o(out_valid_o),
    .out_ready_i(out_ready),
    .out_mask_o (out_mask_o),
    .out_instr_o(out_instr_o),
    .busy_o     (busy_o),
    .split_cnt_o(split_cnt_o)
  );

  int checks = 0;
  int errors = 0;

  // Model: the held bundle is a precomputed list of groups still to issue.
  logic [W-1:0]    m_q[$];
  logic [W-1:0]    calc_q[$];
  logic [W*32-1:0] m_instr = '0;
  int              m_split = 0;
  bit              m_first = 1'b0;
  bit              acc_seen;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] fld(input logic [W*32-1:0] ins, input int lane, input int lsb);
    return ins[lane*32 + lsb +: 5];
  endfunction

  function automatic bit conflicts(input int i, input int k, input logic [W*32-1:0] ins,
                                   input logic [W-1:0] wb, input logic [W-1:0] r1,
                                   input logic [W-1:0] r2);
    logic [4:0] d;
    d = fld(ins, i, 7);
    if (!wb[i] || d == 5'd0) return 1'b0;
    return (r1[k] && fld(ins, k, 15) == d) || (r2[k] && fld(ins, k, 20) == d) ||
           (wb[k] && fld(ins, k, 7) == d);
  endfunction

  function automatic void calc_groups(input logic [W-1:0] mask, input logic [W*32-1:0] ins,
                                      input logic [W-1:0] wb, input logic [W-1:0] r1,
                                      input logic [W-1:0] r2);
    logic [W-1:0] remaining;
    logic [W-1:0] grp;
    bit           done;
    calc_q.delete();
    remaining = mask;
    while (remaining != '0) begin
      grp  = '0;
      done = 1'b0;
      for (int k = 0; k < W; k++) begin
        if (remaining[k] && !done) begin
          for (int i = 0; i < k; i++) if (grp[i] && conflicts(i, k, ins, wb, r1, r2)) done = 1'b1;
          if (!done) grp[k] = 1'b1;
        end
      end
      calc_q.push_back(grp);
      remaining &= ~grp;
    end
  endfunction

  function automatic void model_reset();
    m_q.delete();
    m_instr = '0;
    m_split = 0;
    m_first = 1'b0;
  endfunction

  // Compare all outputs against the model, then advance the model by one clock.
  task automatic step();
    bit           busy;
    bit           exp_ready;
    logic [W-1:0] exp_mask;
    busy      = (m_q.size() != 0);
    exp_mask  = busy ? m_q[0] : '0;
    exp_ready = !flush && (!busy || (out_ready && m_q.size() == 1));
    chk("out_valid", 128'(out_valid_o), 128'(busy));
    chk("busy", 128'(busy_o), 128'(busy));
    chk("out_mask", 128'(out_mask_o), 128'(exp_mask));
    chk("in_ready", 128'(in_ready_o), 128'(exp_ready));
    chk("out_instr", 128'(out_instr_o), 128'(m_instr));
    chk("split_cnt", 128'(split_cnt_o), STATS ? 128'(m_split) : 128'(0));
    acc_seen = in_valid && exp_ready;
    if (busy && out_ready) begin
      if (m_first && m_q.size() > 1 && m_split < (1 << SW) - 1) m_split++;
      m_first = 1'b0;
      void'(m_q.pop_front());
    end
    if (acc_seen && in_mask != '0) begin
      calc_groups(in_mask, in_instr, in_wb, in_r1, in_r2);
      m_q     = calc_q;
      m_instr = in_instr;
      m_first = 1'b1;
    end
    if (flush) begin
      m_q.delete();
      m_first = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] mk(input int rd, input int rs1, input int rs2);
    return {7'h00, 5'(rs2), 5'(rs1), 3'b000, 5'(rd), 7'h33};
  endfunction

  task automatic set_lane(input int l, input int rd, input int rs1, input int rs2,
                          input bit wb, input bit r1, input bit r2);
    in_instr[l*32 +: 32] = mk(rd, rs1, rs2);
    in_wb[l] = wb;
    in_r1[l] = r1;
    in_r2[l] = r2;
  endtask

  task automatic load_indep();
    in_mask = 4'b1111;
    for (int l = 0; l < W; l++) set_lane(l, l + 1, l + 10, l + 10, 1, 1, 1);
  endtask

  // lane0 writes x5, lane2 reads it as rs1.
  task automatic load_raw();
    in_mask = 4'b1111;
    set_lane(0, 5, 20, 21, 1, 1, 1);
    set_lane(1, 6, 22, 23, 1, 1, 1);
    set_lane(2, 7, 5, 24, 1, 1, 0);
    set_lane(3, 8, 25, 26, 1, 1, 1);
  endtask

  task automatic reset_outputs_literal(input string tag);
    chk({tag, "_valid"}, 128'(out_valid_o), 128'(0));
    chk({tag, "_mask"}, 128'(out_mask_o), 128'(0));
    chk({tag, "_instr"}, 128'(out_instr_o), 128'(0));
    chk({tag, "_busy"}, 128'(busy_o), 128'(0));
    chk({tag, "_split"}, 128'(split_cnt_o), 128'(0));
    chk({tag, "_ready"}, 128'(in_ready_o), 128'(1));
  endtask

  initial begin
    #2;
    reset_outputs_literal("rst");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

    // Independent bundle: one group, first group in cycle N+1.
    out_ready = 1'b1;
    load_indep();
    calc_groups(in_mask, in_instr, in_wb, in_r1, in_r2);
    chk("pin_indep_n", 128'(calc_q.size()), 128'(1));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("indep_grp", 128'(out_mask_o), 128'(4'b1111));
    tick();
    chk("indep_split", 128'(split_cnt_o), 128'(0));

    // RAW split.
    load_raw();
    calc_groups(in_mask, in_instr, in_wb, in_r1, in_r2);
    chk("pin_raw_n", 128'(calc_q.size()), 128'(2));
    chk("pin_raw_g0", 128'(calc_q[0]), 128'(4'b0011));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("raw_g0", 128'(out_mask_o), 128'(4'b0011));
    tick();
    chk("raw_g1", 128'(out_mask_o), 128'(4'b1100));
    tick();
    chk("raw_split", 128'(split_cnt_o), STATS ? 128'(1) : 128'(0));

    // x0 write is never a hazard.
    load_indep();
    set_lane(0, 0, 12, 13, 1, 1, 1);
    set_lane(1, 2, 0, 0, 1, 1, 1);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("x0_grp", 128'(out_mask_o), 128'(4'b1111));
    tick();

    // Masked holes never conflict.
    in_mask = 4'b1010;
    set_lane(0, 9, 1, 1, 1, 1, 1);
    set_lane(1, 9, 2, 3, 1, 1, 1);
    set_lane(2, 4, 9, 9, 1, 1, 1);
    set_lane(3, 6, 7, 9, 1, 0, 1);
    calc_groups(in_mask, in_instr, in_wb, in_r1, in_r2);
    chk("pin_hole_g1", 128'(calc_q[1]), 128'(4'b1000));
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("hole_g0", 128'(out_mask_o), 128'(4'b0010));
    tick();
    chk("hole_g1", 128'(out_mask_o), 128'(4'b1000));
    tick();

    // Backpressure holds the group stable and refuses input.
    load_raw();
    out_ready = 1'b0;
    in_valid = 1'b1;
    tick();
    for (int c = 0; c < 3; c++) begin
      chk("bp_mask", 128'(out_mask_o), 128'(4'b0011));
      chk("bp_ready", 128'(in_ready_o), 128'(0));
      chk("bp_busy", 128'(busy_o), 128'(1));
      tick();
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tick();

    // Back-to-back bundles with no bubble.
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int b = 0; b < 6; b++) begin
      if (b % 2 == 0) load_indep();
      else load_raw();
      acc_seen = 1'b0;
      for (int t = 0; t < 4 && !acc_seen; t++) begin
        tick();
        chk("b2b_valid", 128'(out_valid_o), 128'(1));
      end
      if (!acc_seen) chk("b2b_accept", 128'(0), 128'(1));
    end
    in_valid = 1'b0;
    for (int t = 0; t < 3; t++) tick();

    // Flush with P=1100 refuses the offered bundle.
    load_raw();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    chk("fl_pend", 128'(out_mask_o), 128'(4'b1100));
    load_indep();
    in_valid = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("fl_valid", 128'(out_valid_o), 128'(0));
    chk("fl_busy", 128'(busy_o), 128'(0));
    tick();
    chk("fl_noacc", 128'(out_valid_o), 128'(0));

    // Asynchronous reset mid-HOLD.
    load_raw();
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    rst = 1'b1;
    #1;
    reset_outputs_literal("arst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Randomized traffic.
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 19) == 0);
      in_mask   = W'($urandom);
      in_wb     = W'($urandom);
      in_r1     = W'($urandom);
      in_r2     = W'($urandom);
      for (int l = 0; l < W; l++) begin
        in_instr[l*32 +: 32] = mk($urandom_range(0, 3), $urandom_range(0, 3),
                                  $urandom_range(0, 3));
      end
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
